// File: rtl/led_shift_engine.sv
// LED-pattern shift engine: prescaled stepping through shift, rotate and bounce patterns,
// with synchronous parallel load and registered tick/wrap pulses.
module led_shift_engine #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DIV       = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {1'b1, {(WIDTH - 1){1'b0}}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             s_in,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out,
    output logic             dir_out,
    output logic             tick,
    output logic             wrap
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

    typedef enum logic [2:0] {
        ModeHold   = 3'b000,
        ModeShr    = 3'b001,
        ModeShl    = 3'b010,
        ModeRor    = 3'b011,
        ModeRol    = 3'b100,
        ModeBounce = 3'b101,
        ModeRsv6   = 3'b110,
        ModeRsv7   = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    logic             step;
    logic             reversal;
    logic [WIDTH-1:0] rot_r;
    logic [WIDTH-1:0] rot_l;

    always_comb begin
        step     = en & (cnt_q == CntMax);
        rot_r    = {q_q[0], q_q[WIDTH-1:1]};
        rot_l    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        cnt_d    = cnt_q;
        q_d      = q_q;
        dir_d    = dir_q;
        reversal = 1'b0;

        if (en) begin
            cnt_d = step ? '0 : cnt_q + CW'(1);
        end

        if (step) begin
            case (mode_e'(mode))
                ModeShr: q_d = {s_in, q_q[WIDTH-1:1]};
                ModeShl: q_d = {q_q[WIDTH-2:0], s_in};
                ModeRor: q_d = rot_r;
                ModeRol: q_d = rot_l;
                ModeBounce: begin
                    // Reversal only looks at the end bit in the current travel direction.
                    if (!dir_q && q_q[0]) begin
                        dir_d    = 1'b1;
                        reversal = 1'b1;
                        q_d      = rot_l;
                    end else if (dir_q && q_q[WIDTH-1]) begin
                        dir_d    = 1'b0;
                        reversal = 1'b1;
                        q_d      = rot_r;
                    end else begin
                        q_d = dir_q ? rot_l : rot_r;
                    end
                end
                default: q_d = q_q;
            endcase
        end

        tick_d = step;
        wrap_d = step & reversal;

        if (load) begin
            q_d    = d_in;
            cnt_d  = '0;
            dir_d  = 1'b0;
            tick_d = 1'b0;
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign q_out   = q_q;
    assign dir_out = dir_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_led_shift_engine.sv
// Scoreboard bench for led_shift_engine: three instances (DIV = 4, 1, 2) with per-instance
// expected-step queues popped by monitors whenever tick is presented.
module tb_led_shift_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] q;
        logic       dir;
        logic       wrap;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t exp_c[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic       rst_a, en_a, s_in_a, load_a, dir_a, tick_a, wrap_a;
    logic [2:0] mode_a;
    logic [7:0] d_a, q_a;
    logic       rst_b, en_b, s_in_b, load_b, dir_b, tick_b, wrap_b;
    logic [2:0] mode_b;
    logic [7:0] d_b, q_b;
    logic       rst_c, en_c, s_in_c, load_c, dir_c, tick_c, wrap_c;
    logic [2:0] mode_c;
    logic [7:0] d_c, q_c;

    led_shift_engine #(.WIDTH(8), .DIV(4), .RESET_VAL(8'h80)) u_a (
        .clk(clk), .reset(rst_a), .en(en_a), .mode(mode_a), .s_in(s_in_a), .load(load_a),
        .d_in(d_a), .q_out(q_a), .dir_out(dir_a), .tick(tick_a), .wrap(wrap_a)
    );
    led_shift_engine #(.WIDTH(8), .DIV(1), .RESET_VAL(8'h80)) u_b (
        .clk(clk), .reset(rst_b), .en(en_b), .mode(mode_b), .s_in(s_in_b), .load(load_b),
        .d_in(d_b), .q_out(q_b), .dir_out(dir_b), .tick(tick_b), .wrap(wrap_b)
    );
    led_shift_engine #(.WIDTH(8), .DIV(2), .RESET_VAL(8'h80)) u_c (
        .clk(clk), .reset(rst_c), .en(en_c), .mode(mode_c), .s_in(s_in_c), .load(load_c),
        .d_in(d_c), .q_out(q_c), .dir_out(dir_c), .tick(tick_c), .wrap(wrap_c)
    );

    logic [7:0] shr_seq [7]  = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    logic [7:0] bnc_seq [15] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                                 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst_a && tick_a) begin
            if (exp_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_tick: unexpected tick, q=%h", q_a);
            end else begin
                e = exp_a.pop_front();
                chk("a_q", q_a, e.q);
                chk("a_dir", dir_a, e.dir);
                chk("a_wrap", wrap_a, e.wrap);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst_b && tick_b) begin
            if (exp_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_tick: unexpected tick, q=%h", q_b);
            end else begin
                e = exp_b.pop_front();
                chk("b_q", q_b, e.q);
                chk("b_dir", dir_b, e.dir);
                chk("b_wrap", wrap_b, e.wrap);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (!rst_c && tick_c) begin
            if (exp_c.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL c_tick: unexpected tick, q=%h", q_c);
            end else begin
                e = exp_c.pop_front();
                chk("c_q", q_c, e.q);
                chk("c_dir", dir_c, e.dir);
                chk("c_wrap", wrap_c, e.wrap);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int found;
        rst_a = 1'b1; en_a = 1'b0; s_in_a = 1'b0; load_a = 1'b0; mode_a = 3'd0; d_a = 8'h00;
        rst_b = 1'b1; en_b = 1'b0; s_in_b = 1'b0; load_b = 1'b0; mode_b = 3'd0; d_b = 8'h00;
        rst_c = 1'b1; en_c = 1'b0; s_in_c = 1'b0; load_c = 1'b0; mode_c = 3'd0; d_c = 8'h00;

        #12;
        chk("rst_q", q_a, 8'h80);
        chk("rst_dir", dir_a, 1'b0);
        chk("rst_tick", tick_a, 1'b0);
        chk("rst_wrap", wrap_a, 1'b0);
        @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // A: hold-mode tick, then asynchronous reset while tick is high
        load_a = 1'b1; d_a = 8'h3C; mode_a = 3'b000; en_a = 1'b1;
        cyc(1);
        load_a = 1'b0;
        exp_a.push_back({8'h3C, 1'b0, 1'b0});
        cyc(3);
        @(posedge clk);
        #7;
        chk("a_tick_before_reset", tick_a, 1'b1);
        rst_a = 1'b1;
        #1;
        chk("a_async_rst_q", q_a, 8'h80);
        chk("a_async_rst_dir", dir_a, 1'b0);
        chk("a_async_rst_tick", tick_a, 1'b0);
        chk("a_sb_drain1", exp_a.size(), 0);
        @(posedge clk);
        #1;
        mode_a = 3'b011;
        exp_a.push_back({8'h40, 1'b0, 1'b0});
        rst_a = 1'b0;
        found = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (tick_a) begin
                found = i;
                break;
            end
        end
        chk("a_first_tick_edge", found, 4);

        // A: load wins over a coincident bounce step while dir = 1
        load_a = 1'b1; d_a = 8'h01; mode_a = 3'b101;
        cyc(1);
        load_a = 1'b0;
        exp_a.push_back({8'h02, 1'b1, 1'b1});
        cyc(4);
        chk("a_dir_before_load", dir_a, 1'b1);
        cyc(3);
        load_a = 1'b1; d_a = 8'h5A;
        cyc(1);
        chk("a_load_q", q_a, 8'h5A);
        chk("a_load_dir", dir_a, 1'b0);
        chk("a_load_tick", tick_a, 1'b0);
        chk("a_load_wrap", wrap_a, 1'b0);
        load_a = 1'b0;
        exp_a.push_back({8'h2D, 1'b0, 1'b0});
        found = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (tick_a) begin
                found = i;
                break;
            end
        end
        chk("a_tick_after_load", found, 4);
        en_a = 1'b0;
        cyc(2);
        chk("a_sb_drain2", exp_a.size(), 0);

        // B (DIV=1): shift right with fill of ones
        mode_b = 3'b001; s_in_b = 1'b1;
        for (int i = 0; i < 7; i++) exp_b.push_back({shr_seq[i], 1'b0, 1'b0});
        en_b = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("b_shr_tick_every", tick_b, 1'b1);
        end
        en_b = 1'b0;
        cyc(1);
        chk("b_shr_final", q_b, 8'hFF);

        // B: full bounce cycle from 0x80
        load_b = 1'b1; d_b = 8'h80; mode_b = 3'b101;
        cyc(1);
        load_b = 1'b0;
        for (int i = 0; i < 15; i++)
            exp_b.push_back({bnc_seq[i], (i >= 7 && i <= 13), (i == 7 || i == 14)});
        en_b = 1'b1;
        cyc(15);
        en_b = 1'b0;
        cyc(1);
        chk("b_bounce_drain", exp_b.size(), 0);

        // B: all-zero bounce never reverses
        load_b = 1'b1; d_b = 8'h00;
        cyc(1);
        load_b = 1'b0;
        for (int i = 0; i < 20; i++) exp_b.push_back({8'h00, 1'b0, 1'b0});
        en_b = 1'b1;
        cyc(20);
        en_b = 1'b0;
        cyc(1);

        // B: all-ones bounce reverses every step
        load_b = 1'b1; d_b = 8'hFF;
        cyc(1);
        load_b = 1'b0;
        for (int i = 0; i < 6; i++) exp_b.push_back({8'hFF, (i % 2 == 0), 1'b1});
        en_b = 1'b1;
        cyc(6);
        en_b = 1'b0;
        cyc(1);

        // B: reserved mode holds but still ticks; s_in ignored
        load_b = 1'b1; d_b = 8'h3C; mode_b = 3'b111; s_in_b = 1'b1;
        cyc(1);
        load_b = 1'b0;
        for (int i = 0; i < 3; i++) exp_b.push_back({8'h3C, 1'b0, 1'b0});
        en_b = 1'b1;
        cyc(3);
        en_b = 1'b0;
        cyc(1);

        // B: shift left with zero fill
        load_b = 1'b1; d_b = 8'h81; mode_b = 3'b010; s_in_b = 1'b0;
        cyc(1);
        load_b = 1'b0;
        exp_b.push_back({8'h02, 1'b0, 1'b0});
        exp_b.push_back({8'h04, 1'b0, 1'b0});
        en_b = 1'b1;
        cyc(2);
        en_b = 1'b0;
        cyc(2);
        chk("b_sb_drain", exp_b.size(), 0);

        // C (DIV=2): rotate left, then freeze with en low mid-count
        load_c = 1'b1; d_c = 8'h81; mode_c = 3'b100; en_c = 1'b1;
        cyc(1);
        load_c = 1'b0;
        exp_c.push_back({8'h03, 1'b0, 1'b0});
        exp_c.push_back({8'h06, 1'b0, 1'b0});
        cyc(2);
        chk("c_rol_2clk", q_c, 8'h03);
        cyc(2);
        chk("c_rol_4clk", q_c, 8'h06);
        cyc(1);
        chk("c_midcount_tick", tick_c, 1'b0);
        en_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("c_frozen_q", q_c, 8'h06);
            chk("c_frozen_tick", tick_c, 1'b0);
        end
        en_c = 1'b1;
        exp_c.push_back({8'h0C, 1'b0, 1'b0});
        cyc(1);
        chk("c_resume_tick", tick_c, 1'b1);
        chk("c_resume_q", q_c, 8'h0C);
        en_c = 1'b0;
        cyc(2);
        chk("c_sb_drain", exp_c.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_shift_engine.md
Name: led_shift_engine

Overview:
- Parametrised LED-pattern shift engine and the successor to the team's fixed 8-bit SIPO LED shifter.
- Generalised in width, with a built-in step-rate prescaler and parallel load.
- Modes: shift left, shift right, rotate left, rotate right, and bounce (ping-pong).
- Drives the LED bank directly. Sits between the board clock/switch inputs and the LED pins in the LED-effect designs.

Parameters:
- WIDTH, 8: register/LED width, >= 2.
- DIV, 4: enabled clocks per pattern step, >= 1.
- RESET_VAL, 8'h80 (MSB only set, WIDTH bits): value loaded by reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  prescaler count enable; 0 freezes the engine.
- mode  input  3  step operation select (see Behaviour).
- s_in  input  1  serial fill bit for the shift modes.
- load  input  1  synchronous parallel-load strobe.
- d_in  input  WIDTH  parallel load data.
- q_out  output  WIDTH  pattern register.
- dir_out  output  1  bounce direction: 0 = right (toward bit 0), 1 = left.
- tick  output  1  one-cycle pulse, high in the cycle a new stepped value first appears on q_out.
- wrap  output  1  one-cycle pulse, high in the cycle a bounce direction reversal first appears.

Behaviour:
- Reset (asynchronous, any time, including mid-step):
  - q_out = RESET_VAL; prescaler cnt = 0; dir_out = 0; tick = 0; wrap = 0.
- Prescaler:
  - cnt has ceil(log2(DIV)) bits, minimum 1.
  - When en = 1: cnt increments; step = (cnt == DIV-1), and on step cnt wraps to 0.
  - When en = 0: cnt holds and step = 0.
  - DIV = 1: step on every enabled clock.
- Priority: reset > load > step.
- load = 1 (regardless of en or step):
  - q_out <= d_in; cnt <= 0; dir_out <= 0; tick <= 0; wrap <= 0.
- On step, by mode:
  - 000 hold: q unchanged, tick still pulses.
  - 001 shift right: q <= {s_in, q[WIDTH-1:1]}.
  - 010 shift left: q <= {q[WIDTH-2:0], s_in}.
  - 011 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 bounce:
    - If dir = 0 and q[0] = 1: dir <= 1, wrap pulses, q rotates left this step.
    - Else if dir = 1 and q[WIDTH-1] = 1: dir <= 0, wrap pulses, q rotates right this step.
    - Otherwise q rotates in the current direction.
  - 110 and 111: reserved, behave as hold (tick pulses, q unchanged).
- dir_out changes only in bounce mode, on load, or on reset. Other modes leave it unchanged.
- tick, wrap: registered.
  - tick <= step & ~load.
  - wrap <= step & ~load & bounce reversal.
  - Both are never high for more than one consecutive cycle unless DIV = 1 with continuous steps.
- Mode change mid-count: takes effect at the next step. cnt is not cleared.
- Boundaries:
  - All-zero pattern in bounce: rotates zeros, never reverses.
  - All-ones pattern in bounce: reverses every step; wrap pulses each step; q stays all-ones.
  - Both end bits set: reversal is evaluated on the current dir end only.
  - s_in is sampled only on a step in modes 001 and 010.
- No combinational path from any input to any output.

Test Plan:
- Reset behaviour: WIDTH=8, DIV=4, assert reset mid-count with q=8'h3C -> q_out=8'h80, dir_out=0, tick=0 immediately. After release with en=1, first tick occurs on the 4th rising edge.
- Shift right with fill: DIV=1, mode=001, s_in=1, from 8'h80 -> q_out sequence 8'hC0, 8'hE0, 8'hF0, …, 8'hFF after 7 steps. tick high every cycle.
- Rotate modes: DIV=2, mode=100, from load 8'h81 -> 8'h03 after 2 clocks, 8'h06 after 4 clocks. Drop en for 5 cycles -> q_out, cnt and tick frozen.
- Bounce full cycle: DIV=1, mode=101, from 8'h80:
  - 7 steps reach 8'h01.
  - 8th step gives 8'h02 with dir_out=1 and wrap high for exactly that cycle.
  - 14th step gives 8'h80.
  - 15th step gives 8'h40 with dir_out=0 and a second wrap pulse.
- Load priority: load=1 with d_in=8'h5A coincident with a step in bounce, dir=1 -> q_out=8'h5A, dir_out=0, tick=0, cnt restarts (next tick DIV clocks later).
- Degenerate patterns: bounce on 8'h00 -> no wrap over 20 steps. Bounce on 8'hFF -> wrap every step, q_out stays 8'hFF. Reserved mode 111 -> q_out holds, tick still pulses.
